// File: rtl/lc4_trace_pkg.sv
// Shared definitions for the LC4 retire-trace monitor: FSM states, stall classes,
// trace record layout and a saturating counter helper.
package lc4_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    STALL_EXEC   = 2'd0,
    STALL_CACHE  = 2'd1,
    STALL_BRANCH = 2'd2,
    STALL_LOAD   = 2'd3
  } stall_e;

  localparam logic [19:0] HALT_INSN_DEFAULT = 20'h88000;

  // Record layout, MSB first: {halt, pc, insn, rf_we, wsel, nzp_we, nzp, dmem_we, dmem_addr}
  localparam int REC_W         = 48;
  localparam int REC_HALT      = 47;
  localparam int REC_PC_LSB    = 36;
  localparam int REC_INSN_LSB  = 16;
  localparam int REC_RF_WE     = 15;
  localparam int REC_WSEL_LSB  = 10;
  localparam int REC_NZP_WE    = 9;
  localparam int REC_NZP_LSB   = 6;
  localparam int REC_DMEM_WE   = 5;
  localparam int REC_DMEM_LSB  = 0;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/lc4_trace_fifo.sv
// Synchronous FIFO with zero-latency head output; a pop frees a slot for a
// same-cycle push even when full.
module lc4_trace_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/lc4_trace_monitor.sv
// Samples LC4 retire/stall activity on gwe, keeps performance counters and
// queues one trace record per retired instruction for a ready/valid consumer.
module lc4_trace_monitor
  import lc4_trace_pkg::*;
#(
  parameter int              FIFO_DEPTH    = 8,
  parameter int              IADDR         = 10,
  parameter int              INSN          = 19,
  parameter int              REG_ADDR_BITS = 5,
  parameter logic [INSN:0]   HALT_INSN     = HALT_INSN_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     gwe,
  input  logic                     i_start,
  input  logic                     i_clear,
  input  logic [1:0]               test_stall,
  input  logic [IADDR:0]           test_cur_pc,
  input  logic [INSN:0]            test_cur_insn,
  input  logic                     test_regfile_we,
  input  logic                     test_nzp_we,
  input  logic                     test_dmem_we,
  input  logic [REG_ADDR_BITS-1:0] test_regfile_wsel,
  input  logic [REG_ADDR_BITS-1:0] test_dmem_addr,
  input  logic [2:0]               test_nzp_new_bits,
  output logic                     o_rec_valid,
  input  logic                     i_rec_ready,
  output logic [REC_W-1:0]         o_rec_data,
  output logic [31:0]              o_num_cycles,
  output logic [31:0]              o_num_exec,
  output logic [31:0]              o_num_cache_stall,
  output logic [31:0]              o_num_branch_stall,
  output logic [31:0]              o_num_load_stall,
  output logic [15:0]              o_num_dropped,
  output logic                     o_overflow,
  output logic                     o_halted
);

  state_e           state_q, state_d;
  logic             sample, retire, is_halt, pop, drop;
  logic             fifo_full, fifo_empty;
  logic [REC_W-1:0] rec;

  assign is_halt = (test_cur_insn == HALT_INSN);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (i_start) state_d = ST_RUN;
        ST_RUN:    if (retire && is_halt) state_d = ST_HALTED;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Clear wins over a same-cycle sample, so nothing gets counted or queued then.
  always_comb begin
    sample   = (state_q == ST_RUN) && gwe && !i_clear;
    retire   = sample && (stall_e'(test_stall) == STALL_EXEC);
    o_halted = (state_q == ST_HALTED);
  end

  always_comb begin
    rec                                        = '0;
    rec[REC_HALT]                              = is_halt;
    rec[REC_PC_LSB   +: IADDR+1]               = test_cur_pc;
    rec[REC_INSN_LSB +: INSN+1]                = test_cur_insn;
    rec[REC_RF_WE]                             = test_regfile_we;
    rec[REC_WSEL_LSB +: REG_ADDR_BITS]         = test_regfile_wsel;
    rec[REC_NZP_WE]                            = test_nzp_we;
    rec[REC_NZP_LSB  +: 3]                     = test_nzp_new_bits;
    rec[REC_DMEM_WE]                           = test_dmem_we;
    rec[REC_DMEM_LSB +: REG_ADDR_BITS]         = test_dmem_addr;
  end

  assign o_rec_valid = !fifo_empty;
  assign pop         = o_rec_valid && i_rec_ready;
  assign drop        = retire && fifo_full && !pop;

  lc4_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (i_clear),
    .push      (retire),
    .push_data (rec),
    .pop       (pop),
    .pop_data  (o_rec_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      o_num_cycles       <= '0;
      o_num_exec         <= '0;
      o_num_cache_stall  <= '0;
      o_num_branch_stall <= '0;
      o_num_load_stall   <= '0;
      o_num_dropped      <= '0;
      o_overflow         <= 1'b0;
    end else begin
      if (sample) begin
        o_num_cycles <= sat_inc32(o_num_cycles);
        case (stall_e'(test_stall))
          STALL_EXEC:   o_num_exec         <= sat_inc32(o_num_exec);
          STALL_CACHE:  o_num_cache_stall  <= sat_inc32(o_num_cache_stall);
          STALL_BRANCH: o_num_branch_stall <= sat_inc32(o_num_branch_stall);
          default:      o_num_load_stall   <= sat_inc32(o_num_load_stall);
        endcase
      end
      if (drop) begin
        if (!(&o_num_dropped)) o_num_dropped <= o_num_dropped + 16'd1;
        o_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lc4_trace_monitor.sv
// Self-checking bench for lc4_trace_monitor: a small behavioural model predicts
// which records get queued, and a scoreboard compares them as they drain.
module tb_lc4_trace_monitor;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, gwe, i_start, i_clear, i_rec_ready;
  logic [1:0]  test_stall;
  logic [10:0] test_cur_pc;
  logic [19:0] test_cur_insn;
  logic        test_regfile_we, test_nzp_we, test_dmem_we;
  logic [4:0]  test_regfile_wsel, test_dmem_addr;
  logic [2:0]  test_nzp_new_bits;
  logic        o_rec_valid, o_overflow, o_halted;
  logic [47:0] o_rec_data;
  logic [31:0] o_num_cycles, o_num_exec, o_num_cache_stall, o_num_branch_stall, o_num_load_stall;
  logic [15:0] o_num_dropped;

  int checks = 0;
  int errors = 0;

  logic [47:0] sb[$];
  int          m_state = 0;   // 0 idle, 1 run, 2 halted
  bit          m_known = 1'b0;

  always #5 clk = ~clk;

  lc4_trace_monitor #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .gwe(gwe), .i_start(i_start), .i_clear(i_clear),
    .test_stall(test_stall), .test_cur_pc(test_cur_pc), .test_cur_insn(test_cur_insn),
    .test_regfile_we(test_regfile_we), .test_nzp_we(test_nzp_we), .test_dmem_we(test_dmem_we),
    .test_regfile_wsel(test_regfile_wsel), .test_dmem_addr(test_dmem_addr),
    .test_nzp_new_bits(test_nzp_new_bits), .o_rec_valid(o_rec_valid), .i_rec_ready(i_rec_ready),
    .o_rec_data(o_rec_data), .o_num_cycles(o_num_cycles), .o_num_exec(o_num_exec),
    .o_num_cache_stall(o_num_cache_stall), .o_num_branch_stall(o_num_branch_stall),
    .o_num_load_stall(o_num_load_stall), .o_num_dropped(o_num_dropped),
    .o_overflow(o_overflow), .o_halted(o_halted)
  );

  function automatic logic [47:0] exp_rec();
    return {(test_cur_insn == 20'h88000), test_cur_pc, test_cur_insn, test_regfile_we,
            test_regfile_wsel, test_nzp_we, test_nzp_new_bits, test_dmem_we, test_dmem_addr};
  endfunction

  // One clock: check/predict at the negedge with the driven inputs, then return #1 after posedge.
  task automatic tick();
    bit full_before, popped;
    logic [47:0] exp;
    @(negedge clk);
    if (m_known) begin
      checks++;
      if (o_rec_valid !== (sb.size() != 0)) begin
        errors++;
        $display("FAIL rec_valid: got %b want %b", o_rec_valid, sb.size() != 0);
      end
    end
    full_before = (sb.size() == DEPTH);
    popped = 1'b0;
    if (rst || i_clear) begin
      sb.delete();
      m_state = 0;
    end else begin
      if (i_rec_ready && sb.size() > 0) begin
        exp = sb.pop_front();
        popped = 1'b1;
        checks++;
        if (o_rec_data !== exp) begin
          errors++;
          $display("FAIL rec_data: got %h want %h", o_rec_data, exp);
        end
      end
      if (m_state == 1 && gwe && test_stall == 2'd0) begin
        if (!(full_before && !popped)) sb.push_back(exp_rec());
        if (test_cur_insn == 20'h88000) m_state = 2;
      end else if (m_state == 0 && i_start) begin
        m_state = 1;
      end
    end
    if (rst) m_known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [10:0] pc, input logic [19:0] insn);
    gwe = 1'b1; test_stall = 2'd0; test_cur_pc = pc; test_cur_insn = insn;
    test_regfile_we = pc[0]; test_regfile_wsel = pc[4:0] ^ 5'h15; test_nzp_we = pc[1];
    test_nzp_new_bits = pc[3:1]; test_dmem_we = pc[2]; test_dmem_addr = pc[6:2];
    tick();
    gwe = 1'b0;
  endtask

  task automatic clear_and_start();
    gwe = 1'b0; i_rec_ready = 1'b0;
    i_clear = 1'b1; tick(); i_clear = 1'b0;
    i_start = 1'b1; tick(); i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({o_rec_valid, o_overflow, o_halted} !== 3'b000 || o_num_cycles !== 0 || o_num_exec !== 0 ||
        o_num_dropped !== 0) begin
      errors++;
      $display("FAIL reset: valid=%b ovf=%b halted=%b cycles=%0d drop=%0d want all zero",
               o_rec_valid, o_overflow, o_halted, o_num_cycles, o_num_dropped);
    end
  endtask

  task automatic test_stall_classes();
    clear_and_start();
    for (int s = 0; s < 4; s++) begin
      gwe = 1'b1; test_stall = 2'(s); test_cur_pc = 11'h010; test_cur_insn = 20'h12345;
      test_regfile_we = 1'b1; test_regfile_wsel = 5'h07; test_nzp_we = 1'b1;
      test_nzp_new_bits = 3'b010; test_dmem_we = 1'b0; test_dmem_addr = 5'h1c;
      tick();
    end
    gwe = 1'b0;
    checks++;
    if (o_num_cycles !== 32'd4 || o_num_exec !== 32'd1 || o_num_cache_stall !== 32'd1 ||
        o_num_branch_stall !== 32'd1 || o_num_load_stall !== 32'd1) begin
      errors++;
      $display("FAIL stall_counts: cyc=%0d ex=%0d c=%0d b=%0d l=%0d want 4 1 1 1 1", o_num_cycles,
               o_num_exec, o_num_cache_stall, o_num_branch_stall, o_num_load_stall);
    end
    checks++;
    if (o_rec_data[46:36] !== 11'h010) begin
      errors++;
      $display("FAIL stall_rec_pc: got %h want 010", o_rec_data[46:36]);
    end
    i_rec_ready = 1'b1; tick(); tick(); i_rec_ready = 1'b0;
    checks++;
    if (o_rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_one_record: valid=%b want 0 after one pop", o_rec_valid);
    end
  endtask

  task automatic test_halt();
    clear_and_start();
    retire(11'h020, 20'h88000);
    for (int i = 0; i < 3; i++) begin
      gwe = 1'b1; test_stall = 2'd1; tick();
    end
    gwe = 1'b0;
    checks++;
    if (o_halted !== 1'b1 || o_num_cycles !== 32'd1 || o_num_cache_stall !== 32'd0) begin
      errors++;
      $display("FAIL halt_freeze: halted=%b cycles=%0d cache=%0d want 1 1 0", o_halted,
               o_num_cycles, o_num_cache_stall);
    end
    checks++;
    if (o_rec_data[47] !== 1'b1 || o_rec_data[46:36] !== 11'h020) begin
      errors++;
      $display("FAIL halt_rec: halt=%b pc=%h want 1 020", o_rec_data[47], o_rec_data[46:36]);
    end
    i_start = 1'b1; tick(); i_start = 1'b0;
    i_rec_ready = 1'b1; tick(); i_rec_ready = 1'b0;
    checks++;
    if (o_halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_sticky: halted=%b want 1", o_halted);
    end
  endtask

  task automatic test_overflow();
    clear_and_start();
    for (int i = 0; i < 10; i++) retire(11'h100 + 11'(i * 3), 20'h0a000 + 20'(i));
    checks++;
    if (o_num_dropped !== 16'd2 || o_overflow !== 1'b1 || o_num_exec !== 32'd10) begin
      errors++;
      $display("FAIL overflow: dropped=%0d ovf=%b exec=%0d want 2 1 10", o_num_dropped,
               o_overflow, o_num_exec);
    end
    i_rec_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    i_rec_ready = 1'b0;
    checks++;
    if (o_rec_valid !== 1'b0 || o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drain: valid=%b ovf=%b want 0 1", o_rec_valid, o_overflow);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_and_start();
    for (int i = 0; i < DEPTH; i++) retire(11'h200 + 11'(i), 20'h01000 + 20'(i));
    i_rec_ready = 1'b1;
    retire(11'h300, 20'h0beef);
    i_rec_ready = 1'b0; tick();
    checks++;
    if (o_num_dropped !== 16'd0 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop: dropped=%0d ovf=%b want 0 0", o_num_dropped, o_overflow);
    end
    n = 0;
    i_rec_ready = 1'b1;
    for (int k = 0; k < 20 && o_rec_valid === 1'b1; k++) begin
      n++;
      tick();
    end
    i_rec_ready = 1'b0;
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL full_count: drained %0d want %0d", n, DEPTH);
    end
  endtask

  task automatic test_abort(input bit use_rst);
    clear_and_start();
    for (int i = 0; i < 5; i++) retire(11'h040 + 11'(i), 20'h02000 + 20'(i));
    gwe = 1'b1; test_stall = 2'd0; i_start = 1'b1;
    if (use_rst) rst = 1'b1; else i_clear = 1'b1;
    tick();
    rst = 1'b0; i_clear = 1'b0; i_start = 1'b0;
    checks++;
    if (o_rec_valid !== 1'b0 || o_num_cycles !== 0 || o_num_exec !== 0 || o_halted !== 1'b0) begin
      errors++;
      $display("FAIL abort_%0d: valid=%b cycles=%0d exec=%0d want 0 0 0", use_rst, o_rec_valid,
               o_num_cycles, o_num_exec);
    end
    tick(); tick();
    checks++;
    if (o_num_cycles !== 0 || o_rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_%0d: cycles=%0d valid=%b want 0 0", use_rst, o_num_cycles, o_rec_valid);
    end
    gwe = 1'b0; i_start = 1'b1; tick(); i_start = 1'b0;
    gwe = 1'b1; test_stall = 2'd3; tick(); gwe = 1'b0;
    checks++;
    if (o_num_cycles !== 32'd1 || o_num_load_stall !== 32'd1) begin
      errors++;
      $display("FAIL abort_restart_%0d: cycles=%0d load=%0d want 1 1", use_rst, o_num_cycles,
               o_num_load_stall);
    end
  endtask

  initial begin
    rst = 1'b0; gwe = 1'b0; i_start = 1'b0; i_clear = 1'b0; i_rec_ready = 1'b0;
    test_stall = 2'd0; test_cur_pc = '0; test_cur_insn = '0;
    test_regfile_we = 1'b0; test_nzp_we = 1'b0; test_dmem_we = 1'b0;
    test_regfile_wsel = '0; test_dmem_addr = '0; test_nzp_new_bits = '0;
    test_reset();
    test_stall_classes();
    test_halt();
    test_overflow();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc4_trace_monitor.md
LC4_TRACE_MONITOR -- requirements
Module: lc4_trace_monitor

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning trace record FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter IADDR, default 10, meaning PC MSB index, so the PC is 11 bits.
REQ-003 SHALL have parameter INSN, default 19, meaning instruction MSB index, so the instruction is 20 bits.
REQ-004 SHALL have parameter REG_ADDR_BITS, default 5, meaning register and dmem address width.
REQ-005 SHALL have parameter HALT_INSN, default 20'h88000, meaning the halt encoding.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- gwe  in  1  processor global write enable; one sample per high cycle
- i_start  in  1  IDLE->RUN
- i_clear  in  1  zero counters, flush FIFO, go IDLE
- test_stall  in  2  0 exec, 1 cache, 2 branch, 3 load
- test_cur_pc  in  IADDR+1  retiring PC
- test_cur_insn  in  INSN+1  retiring instruction
- test_regfile_we, test_nzp_we, test_dmem_we  in  1 each  retire write enables
- test_regfile_wsel, test_dmem_addr  in  REG_ADDR_BITS each  retire addresses
- test_nzp_new_bits  in  3  NZP value
- o_rec_valid  out  1  record available
- i_rec_ready  in  1  consumer accepts
- o_rec_data  out  48  {halt, pc, insn, regfile_we, wsel, nzp_we, nzp, dmem_we, dmem_addr}, MSB first
- o_num_cycles, o_num_exec, o_num_cache_stall, o_num_branch_stall, o_num_load_stall  out  32 each  counters
- o_num_dropped  out  16  records lost to full FIFO
- o_overflow  out  1  sticky drop flag
- o_halted  out  1  state == HALTED

Function
REQ-008 SHALL implement states IDLE, RUN, HALTED; reset enters IDLE.
REQ-009 IDLE SHALL go to RUN on i_start; i_start SHALL be ignored in RUN and HALTED.
REQ-010 A sample SHALL occur only in RUN with gwe high.
REQ-011 Each sample SHALL increment o_num_cycles and exactly one stall-class counter selected by test_stall.
REQ-012 A sample with test_stall==0 SHALL be a retire and SHALL push one record in the same clk.
REQ-013 A retire with test_cur_insn==HALT_INSN SHALL set the record halt bit and move the state to HALTED on the next clk.
REQ-014 HALTED SHALL take no further samples while the FIFO continues to drain.
REQ-015 All counters SHALL saturate at all-ones and never wrap.
REQ-016 A push with the FIFO full and no pop in that cycle SHALL discard the record, increment o_num_dropped (saturating), and set o_overflow.
REQ-017 Push and pop in the same cycle SHALL both succeed when the FIFO is full or empty-with-valid.
REQ-018 o_rec_valid SHALL equal FIFO not-empty.
REQ-019 o_rec_data SHALL be the head entry and SHALL stay stable while o_rec_valid is high and i_rec_ready is low.
REQ-020 Pop latency SHALL be zero: the handshake o_rec_valid&&i_rec_ready pops in that clk.
REQ-021 Push-to-visible latency SHALL be one clk: o_rec_valid rises the clk after a push into an empty FIFO.
REQ-022 i_clear SHALL zero all counters, clear o_overflow, flush the FIFO, and enter IDLE in any state.
REQ-023 i_clear SHALL take priority over i_start and over a same-cycle sample.

Reset
REQ-024 rst SHALL produce IDLE, an empty FIFO, o_rec_valid=0, all counters 0, o_overflow=0, and o_halted=0 on the next clk.
REQ-025 rst SHALL dominate i_clear, i_start, and samples, including mid-RUN.

Structure
REQ-026 State encoding, record field offsets, and HALT_INSN default SHALL live in shared package lc4_trace_pkg.
REQ-027 The FIFO SHALL be sub-module lc4_trace_fifo (parameterised width/depth, full/empty, synchronous reset); the rest stays in the top.

Verification
REQ-028 Start, then 4 gwe samples with stall 0,1,2,3 at pc 0x010 -> cycles=4, exec=1, cache=1, branch=1, load=1, and one record with pc=0x010.
REQ-029 Retire insn 20'h88000 at pc 0x020, then 3 more gwe samples -> halt bit 1 in the record, o_halted=1, cycles frozen at its halt value.
REQ-030 i_rec_ready=0 and 10 retires with FIFO_DEPTH=8 -> 8 records kept, o_num_dropped=2, o_overflow=1, and order preserved on drain.
REQ-031 FIFO full, then one cycle with a retire and i_rec_ready=1 -> no drop, count stays 8.
REQ-032 rst, or i_clear, asserted mid-RUN with 5 entries queued -> o_rec_valid=0 next clk, counters 0, and IDLE (samples ignored until i_start).
